q_four: RTL and testbench

- Serial pattern-occurrence counter.
- Samples the 1-bit serial stream DAT on every rising clock edge.
- Detects each occurrence of a fixed bit pattern (default "101", overlapping matches allowed) and counts occurrences in a CNT_W-bit registered counter.
- Sits at the edge of a serial receive path as a simple event/statistics monitor.

---
 rtl/q_four_pkg.sv | 15 +
 rtl/q_four_if.sv | 10 +
 rtl/q_four_window.sv | 39 +++
 rtl/q_four.sv | 53 +++++
 tb/tb_q_four.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/q_four_pkg.sv
// Shared constants and the counter-update helper for the q_four pattern counter.
package q_four_pkg;

    localparam int unsigned DEF_PAT_W   = 3;
    localparam logic [2:0]  DEF_PATTERN = 3'b101;
    localparam int unsigned DEF_CNT_W   = 4;

    // sat is true when the counter must hold its value (saturating build at its maximum).
    function automatic logic [31:0] next_count(input logic [31:0] cur,
                                               input logic        match,
                                               input logic        sat);
        next_count = (match && !sat) ? cur + 32'd1 : cur;
    endfunction

endpackage

// File: rtl/q_four_if.sv
// Serial data in / occurrence count out bundle for q_four.
interface q_four_if #(
    parameter int unsigned CNT_W = 4
);
    logic             DAT;
    logic [CNT_W-1:0] counter;

    modport master (output DAT, input counter);
    modport slave  (input DAT, output counter);
endinterface

// File: rtl/q_four_window.sv
// Sliding window over the serial stream: PAT_W-1 history bits plus the live bit,
// with a fill counter so bits from before reset release never form a window.
module q_four_window #(
    parameter int unsigned PAT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dat,
    output logic [PAT_W-1:0] window_c,
    output logic             window_valid_c
);

    localparam int unsigned HIST_W   = PAT_W - 1;
    localparam logic [3:0]  FILL_MAX = 4'(PAT_W - 1);

    logic [HIST_W-1:0] hist_q, hist_d;
    logic [3:0]        fill_q, fill_d;

    always_comb begin
        hist_d = HIST_W'({hist_q, dat});
        fill_d = fill_q;
        if (fill_q != FILL_MAX) begin
            fill_d = fill_q + 4'd1;
        end
        window_c       = {hist_q, dat};
        window_valid_c = (fill_q == FILL_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/q_four.sv
// Counts (overlapping) occurrences of PATTERN in the serial stream bus.DAT.
// Define Q_FOUR_SAT_EN to make the counter saturate instead of wrapping.
module q_four
    import q_four_pkg::*;
#(
    parameter int unsigned      PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
    parameter int unsigned      CNT_W   = DEF_CNT_W
) (
    input  logic   clk,
    input  logic   reset,
    q_four_if.slave bus
);

`ifdef Q_FOUR_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic [PAT_W-1:0] window_c;
    logic             window_valid_c;
    logic             match_c;
    logic             sat_c;
    logic [CNT_W-1:0] counter_q, counter_d;

    q_four_window #(
        .PAT_W (PAT_W)
    ) u_window (
        .clk            (clk),
        .rst_n          (reset),
        .dat            (bus.DAT),
        .window_c       (window_c),
        .window_valid_c (window_valid_c)
    );

    always_comb begin
        match_c   = window_valid_c && (window_c == PATTERN);
        sat_c     = SAT_EN && (counter_q == '1);
        counter_d = CNT_W'(next_count(32'(counter_q), match_c, sat_c));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter_q <= '0;
        end else begin
            counter_q <= counter_d;
        end
    end

    assign bus.counter = counter_q;

endmodule

// File: tb/tb_q_four.sv
// Randomized and directed bench for q_four against a bit-history reference model.
module tb_q_four;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic dat   = 1'b0;

    always #5 clk = ~clk;

    q_four_if #(.CNT_W(4)) bus_a ();
    q_four_if #(.CNT_W(4)) bus_b ();
    q_four_if #(.CNT_W(4)) bus_c ();

    assign bus_a.DAT = dat;
    assign bus_b.DAT = dat;
    assign bus_c.DAT = dat;

    q_four #(.PAT_W(3), .PATTERN(3'b101), .CNT_W(4)) u_dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave));
    q_four #(.PAT_W(3), .PATTERN(3'b001), .CNT_W(4)) u_dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave));
    q_four #(.PAT_W(2), .PATTERN(2'b11), .CNT_W(4)) u_dut_c (
        .clk(clk), .reset(reset), .bus(bus_c.slave));

    int n_checks = 0;
    int n_fail   = 0;
    bit seen_q[$];
    int m_a = 0;
    int m_b = 0;
    int m_c = 0;

    // True when the most recent w bits seen since reset spell pat (LSB = newest).
    function automatic bit ends_with(int w, logic [7:0] pat);
        if (seen_q.size() < w) return 1'b0;
        for (int i = 0; i < w; i++) begin
            if (seen_q[seen_q.size() - 1 - i] != pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [3:0] expect_cnt(int m);
`ifdef Q_FOUR_SAT_EN
        return (m > 15) ? 4'd15 : 4'(m);
`else
        return 4'(m % 16);
`endif
    endfunction

    task automatic check(input string tag);
        n_checks++;
        assert (bus_a.counter === expect_cnt(m_a)) else begin
            n_fail++;
            $error("FAIL %s pat101: observed %0d expected %0d", tag, bus_a.counter, expect_cnt(m_a));
        end
        n_checks++;
        assert (bus_b.counter === expect_cnt(m_b)) else begin
            n_fail++;
            $error("FAIL %s pat001: observed %0d expected %0d", tag, bus_b.counter, expect_cnt(m_b));
        end
        n_checks++;
        assert (bus_c.counter === expect_cnt(m_c)) else begin
            n_fail++;
            $error("FAIL %s pat11: observed %0d expected %0d", tag, bus_c.counter, expect_cnt(m_c));
        end
    endtask

    // Glitch DAT between edges, settle it at negedge, then check just after the posedge.
    task automatic step(input bit b, input string tag);
        dat = ~b;
        @(negedge clk);
        dat = b;
        @(posedge clk);
        #1;
        if (reset) begin
            seen_q.push_back(b);
            if (seen_q.size() > 8) void'(seen_q.pop_front());
            if (ends_with(3, 8'b101)) m_a++;
            if (ends_with(3, 8'b001)) m_b++;
            if (ends_with(2, 8'b11))  m_c++;
        end
        check(tag);
    endtask

    // Assert reset between edges, hold it two cycles with DAT toggling, release between edges.
    task automatic apply_reset();
        #2;
        reset = 1'b0;
        #1;
        seen_q.delete();
        m_a = 0;
        m_b = 0;
        m_c = 0;
        check("rst_async");
        step(1'b1, "rst_hold");
        step(1'b0, "rst_hold");
        #2;
        reset = 1'b1;
        #1;
        check("rst_release");
    endtask

    initial begin
        bit stream_a [12] = '{0, 1, 0, 1, 0, 1, 0, 0, 1, 1, 0, 1};

        apply_reset();

        // Directed stream; also covers the first two bits right after release.
        foreach (stream_a[i]) step(stream_a[i], "stream");

        apply_reset();
        step(1'b1, "overlap");
        step(1'b0, "overlap");
        step(1'b1, "overlap");
        step(1'b0, "overlap");
        step(1'b1, "overlap");

        apply_reset();
        repeat (4) step(1'b1, "ones");

        apply_reset();
        step(1'b0, "first_bits");
        step(1'b1, "first_bits");

        apply_reset();
        repeat (300) step(1'($urandom), "random");

        apply_reset();
        repeat (16) begin
            step(1'b1, "overflow");
            step(1'b0, "overflow");
        end
        step(1'b1, "overflow_end");
        step(1'b0, "overflow_more");
        step(1'b1, "overflow_more");

        apply_reset();
        repeat (3) begin
            step(1'b1, "pre_mid_rst");
            step(1'b0, "pre_mid_rst");
        end
        apply_reset();
        step(1'b1, "post_rst");
        step(1'b0, "post_rst");
        step(1'b1, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
